// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART byte command parser (0xAA addr data = write, 0xBB addr = read) driving RF_* and returning read data on TX_*; CMD_BUSY when not idle; UART_CMD_ERR_DROP_EN aborts frames on errored bytes
module uart_cmd_ctrl #(
  parameter int Data_width = 8,
  parameter int Addr_width = 4,
  parameter int Rd_timeout = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_width-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  input  logic                  TX_BUSY,
  output logic [Data_width-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic [Addr_width-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [Data_width-1:0] RF_WR_DATA,
  output logic                  RF_RD_EN,
  input  logic [Data_width-1:0] RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  output logic                  CMD_BUSY
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_STROBE, RD_ADDR, RD_WAIT, TX_SEND, TX_HOLD} state_t;
  localparam int cnt_w = $clog2(Rd_timeout + 1);
  localparam logic [Data_width-1:0] cmd_wr = Data_width'(8'hAA);
  localparam logic [Data_width-1:0] cmd_rd = Data_width'(8'hBB);
`ifdef UART_CMD_ERR_DROP_EN
  localparam bit err_drop = 1'b1;
`else
  localparam bit err_drop = 1'b0;
`endif
  state_t state;
  logic [cnt_w-1:0] cnt;
  logic err;
  assign err = err_drop && (RX_PAR_ERR || RX_STP_ERR);
  assign CMD_BUSY = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      RF_RD_EN   <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      TX_D_VLD <= 1'b0;
      case (state)
        IDLE:
          if (RX_D_VLD && !err)
            state <= (RX_P_DATA == cmd_wr) ? WR_ADDR : (RX_P_DATA == cmd_rd) ? RD_ADDR : IDLE;
        WR_ADDR:
          if (RX_D_VLD) begin
            state <= err ? IDLE : WR_DATA;
            if (!err) RF_ADDR <= RX_P_DATA[Addr_width-1:0];
          end
        WR_DATA:
          if (RX_D_VLD) begin
            state <= err ? IDLE : WR_STROBE;
            if (!err) RF_WR_DATA <= RX_P_DATA;
          end
        WR_STROBE: begin
          RF_WR_EN <= 1'b1;
          state    <= IDLE;
        end
        RD_ADDR:
          if (RX_D_VLD) begin
            state <= err ? IDLE : RD_WAIT;
            if (!err) begin
              RF_ADDR  <= RX_P_DATA[Addr_width-1:0];
              RF_RD_EN <= 1'b1;
              cnt      <= '0;
            end
          end
        RD_WAIT:
          if (RF_RD_DATA_VLD) begin
            TX_P_DATA <= RF_RD_DATA;
            cnt       <= '0;
            state     <= TX_SEND;
          end else if (cnt == cnt_w'(Rd_timeout - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else
            cnt <= cnt + 1'b1;
        TX_SEND:
          if (!TX_BUSY) begin
            TX_D_VLD <= 1'b1;
            state    <= TX_HOLD;
          end
        TX_HOLD:
          if (TX_BUSY) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboard bench for uart_cmd_ctrl with directed frames, read responder and transmitter model
module tb_uart_cmd_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] rx_p_data = 0;
  logic rx_d_vld = 0, rx_par_err = 0, rx_stp_err = 0;
  logic tx_model = 0, tx_force = 0, tx_busy;
  logic [7:0] tx_p_data, rf_wr_data, rf_rd_data = 0;
  logic tx_d_vld, rf_wr_en, rf_rd_en, rf_rd_data_vld = 0, cmd_busy;
  logic [3:0] rf_addr;
  int cyc = 0, total = 0, bad = 0;
  int rd_lat = 0;
  logic [7:0] rd_val = 0;
`ifdef UART_CMD_ERR_DROP_EN
  localparam bit err_drop = 1'b1;
`else
  localparam bit err_drop = 1'b0;
`endif
  typedef struct {int kind; int addr; int data; int cyc;} exp_t;
  exp_t q[$];
  assign tx_busy = tx_model | tx_force;
  uart_cmd_ctrl dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
    .RX_PAR_ERR(rx_par_err), .RX_STP_ERR(rx_stp_err), .TX_BUSY(tx_busy),
    .TX_P_DATA(tx_p_data), .TX_D_VLD(tx_d_vld), .RF_ADDR(rf_addr),
    .RF_WR_EN(rf_wr_en), .RF_WR_DATA(rf_wr_data), .RF_RD_EN(rf_rd_en),
    .RF_RD_DATA(rf_rd_data), .RF_RD_DATA_VLD(rf_rd_data_vld), .CMD_BUSY(cmd_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic pop_cmp(int kind, int addr, int data);
    exp_t e;
    string nm;
    nm = kind == 0 ? "wr_strobe" : kind == 1 ? "rd_strobe" : "tx_send";
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected: got addr %0h data %0h at cyc %0d, want no event", nm, addr, data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.addr != addr || e.data != data || e.cyc != cyc) begin
      bad++;
      $display("FAIL %s: got kind %0d addr %0h data %0h cyc %0d, want kind %0d addr %0h data %0h cyc %0d",
               nm, kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
    end
  endtask
  function automatic void push(int kind, int addr, int data, int at);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = at;
    q.push_back(e);
  endfunction
  initial forever begin
    @(negedge clk);
    if (rf_wr_en) pop_cmp(0, int'(rf_addr), int'(rf_wr_data));
    if (rf_rd_en) pop_cmp(1, int'(rf_addr), 0);
    if (tx_d_vld) pop_cmp(2, 0, int'(tx_p_data));
  end
  initial forever begin
    @(negedge clk);
    if (rf_rd_en && rd_lat > 0) begin
      repeat (rd_lat - 1) @(negedge clk);
      rf_rd_data = rd_val;
      rf_rd_data_vld = 1;
      @(negedge clk);
      rf_rd_data_vld = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_d_vld) begin
      tx_model = 1;
      repeat (3) @(negedge clk);
      tx_model = 0;
    end
  end
  task automatic send(logic [7:0] b, logic par = 0, logic stp = 0);
    rx_p_data = b; rx_d_vld = 1; rx_par_err = par; rx_stp_err = stp;
    @(negedge clk);
    rx_d_vld = 0; rx_par_err = 0; rx_stp_err = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_zero(string tag);
    check({tag, " tx_p_data"}, int'(tx_p_data), 0);
    check({tag, " tx_d_vld"}, int'(tx_d_vld), 0);
    check({tag, " rf_addr"}, int'(rf_addr), 0);
    check({tag, " rf_wr_en"}, int'(rf_wr_en), 0);
    check({tag, " rf_wr_data"}, int'(rf_wr_data), 0);
    check({tag, " rf_rd_en"}, int'(rf_rd_en), 0);
    check({tag, " cmd_busy"}, int'(cmd_busy), 0);
  endtask
  initial begin
    idle(3);
    check_zero("reset");
    rst = 0;
    idle(2);
    send(8'hAA); send(8'h35);
    check("busy mid write", int'(cmd_busy), 1);
    push(0, 5, 8'h5C, cyc + 2);
    send(8'h5C);
    idle(4);
    check("write idle", int'(cmd_busy), 0);
    send(8'hBB);
    rd_lat = 3; rd_val = 8'hA7;
    push(1, 3, 0, cyc + 1);
    push(2, 0, 8'hA7, cyc + 5);
    send(8'h03);
    idle(10);
    check("read idle", int'(cmd_busy), 0);
    tx_force = 1;
    rd_lat = 1; rd_val = 8'h3C;
    send(8'hBB);
    push(1, 6, 0, cyc + 1);
    send(8'h06);
    idle(5);
    send(8'hAA);
    idle(12);
    check("bp waiting", int'(cmd_busy), 1);
    push(2, 0, 8'h3C, cyc + 1);
    tx_force = 0;
    idle(8);
    check("bp dropped byte", int'(cmd_busy), 0);
    rd_lat = 0;
    send(8'hBB);
    push(1, 2, 0, cyc + 1);
    send(8'h02);
    idle(14);
    check("timeout last wait", int'(cmd_busy), 1);
    idle(1);
    check("timeout idle", int'(cmd_busy), 0);
    send(8'hAA); send(8'h07);
    push(0, 7, 8'h11, cyc + 2);
    send(8'h11);
    idle(4);
    rd_lat = 15; rd_val = 8'h5A;
    send(8'hBB);
    push(1, 9, 0, cyc + 1);
    push(2, 0, 8'h5A, cyc + 17);
    send(8'h09);
    idle(24);
    check("data wins idle", int'(cmd_busy), 0);
    rd_lat = 0;
    send(8'h11); send(8'hAA); send(8'h01);
    check("garbage mid frame", int'(cmd_busy), 1);
    rst = 1;
    idle(1);
    rst = 0;
    check_zero("mid reset");
    send(8'h22);
    idle(4);
    check_zero("after garbage");
    send(8'hAA); send(8'h04);
    if (!err_drop) push(0, 4, 8'h99, cyc + 2);
    send(8'h99, 1, 0);
    idle(3);
    check("err par idle", int'(cmd_busy), 0);
    check("err par data", int'(rf_wr_data), err_drop ? 0 : 8'h99);
    send(8'hAA, 0, 1); send(8'h05);
    if (!err_drop) push(0, 5, 8'h66, cyc + 2);
    send(8'h66);
    idle(3);
    check("err stp data", int'(rf_wr_data), err_drop ? 0 : 8'h66);
    check("err stp idle", int'(cmd_busy), 0);
    idle(5);
    check("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Byte-level command controller on the far side of the UART: consumes received bytes from the UART receiver, parses write/read frames, drives a register-file port, and returns read data to the UART transmitter.
- Sits between the UART block and the system register file, in the REF_CLK domain.
- The UART RX/TX handshake signals reach it already synchronised.

Parameters:
- Data_width, 8, byte width of UART data and register data
- Addr_width, 4, register-file address width
- Rd_timeout, 15, max cycles to wait for read data before abandoning a read

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- RX_P_DATA  in  Data_width  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RX_PAR_ERR  in  1  parity error for current byte
- RX_STP_ERR  in  1  stop error for current byte
- TX_BUSY  in  1  UART transmitter busy
- TX_P_DATA  out  Data_width  byte to transmit
- TX_D_VLD  out  1  one-cycle transmit request
- RF_ADDR  out  Addr_width  register address
- RF_WR_EN  out  1  one-cycle write strobe
- RF_WR_DATA  out  Data_width  write data
- RF_RD_EN  out  1  one-cycle read strobe
- RF_RD_DATA  in  Data_width  read data
- RF_RD_DATA_VLD  in  1  read data valid
- CMD_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0; applies from any state (a mid-frame reset discards the frame).
- Command bytes: 0xAA = write frame (CMD, ADDR, DATA); 0xBB = read frame (CMD, ADDR).
  - Any other byte in IDLE is ignored and the block stays in IDLE.
  - ADDR byte: only the low Addr_width bits are used; upper bits are ignored.
- Byte acceptance: a byte is consumed only on a cycle with RX_D_VLD=1.
- States:
  - IDLE: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR.
  - WR_ADDR: on byte, register address -> WR_DATA.
  - WR_DATA: on byte, register data -> WR_STROBE.
  - WR_STROBE: RF_WR_EN=1 for exactly this cycle, with RF_ADDR/RF_WR_DATA stable -> IDLE.
  - RD_ADDR: on byte, register address -> RD_WAIT.
  - RD_WAIT:
    - RF_RD_EN=1 on the first RD_WAIT cycle only.
    - RF_RD_DATA_VLD is sampled on every RD_WAIT cycle, including the first; on VLD=1, capture RF_RD_DATA into the TX buffer -> TX_SEND.
    - Counter counts RD_WAIT cycles; if it reaches Rd_timeout with no VLD -> IDLE, nothing transmitted.
  - TX_SEND: when TX_BUSY=0, TX_D_VLD=1 for one cycle with TX_P_DATA = buffer -> TX_HOLD. While TX_BUSY=1, wait with TX_D_VLD=0.
  - TX_HOLD: wait for TX_BUSY=1 (transmitter accepted) -> IDLE. TX_P_DATA holds the buffer until leaving TX_HOLD.
- Latency:
  - Write: RF_WR_EN asserts 2 cycles after the RX_D_VLD of the DATA byte.
  - Read: RF_RD_EN asserts 1 cycle after the RX_D_VLD of the ADDR byte.
- Flow control: RX_D_VLD pulses arriving in WR_STROBE, RD_WAIT, TX_SEND or TX_HOLD are dropped, with no state effect.
- RF_ADDR holds its last value between frames; RF_WR_DATA changes only in WR_DATA.
- Simultaneous events: RF_RD_DATA_VLD on the same cycle the counter reaches Rd_timeout: data wins -> TX_SEND.

Optional Feature:
- Macro: UART_CMD_ERR_DROP_EN.
- Defined: a byte accepted with RX_PAR_ERR=1 or RX_STP_ERR=1 aborts the current frame. State -> IDLE; no RF strobe is issued for that frame; the byte is not interpreted as a command even in IDLE.
- Undefined: the error inputs are ignored (ports remain, unused) and erroneous bytes are parsed normally.

Test Plan:
- Write: bytes 0xAA, 0x35, 0x5C -> one RF_WR_EN pulse with RF_ADDR=0x5 and RF_WR_DATA=0x5C, 2 cycles after the third RX_D_VLD; state returns to IDLE.
- Read: bytes 0xBB, 0x03; RF_RD_DATA_VLD=1 with 0xA7 on the 3rd RD_WAIT cycle -> one RF_RD_EN pulse with RF_ADDR=0x3, then a single TX_D_VLD pulse with TX_P_DATA=0xA7.
- TX backpressure: read completes while TX_BUSY=1 for 20 cycles -> TX_D_VLD stays 0 until TX_BUSY falls, then pulses once; an RX byte sent during the wait is dropped.
- Read timeout: 0xBB, 0x02, no RF_RD_DATA_VLD -> IDLE after 15 RD_WAIT cycles, no TX_D_VLD; a following 0xAA frame works normally.
- Garbage and reset: bytes 0x11, 0xAA, 0x01, then RST high for 1 cycle, then 0x22 -> no RF_WR_EN, all outputs 0, CMD_BUSY=0.
- With UART_CMD_ERR_DROP_EN: 0xAA, 0x04, then 0x99 with RX_PAR_ERR=1 -> no RF_WR_EN, IDLE. Without the macro, the same stimulus writes 0x99 to address 4.
